// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the 16x8 scratch memory family: geometry constants,
// address/data word types and the read-side FSM state encoding.
package mem_pkg;

    localparam int MEM_ADDR_W = 4;
    localparam int MEM_DATA_W = 8;
    localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;

    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
    typedef logic [MEM_DATA_W-1:0] mem_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Bundle of the burst-request port, the memory read port and the output
// stream of the memory stream reader. The reader uses the master view; the
// surrounding system (requester, memory, consumer) uses the slave view.
interface mem_stream_reader_if #(
    parameter int ADDR_W = mem_pkg::MEM_ADDR_W,
    parameter int DATA_W = mem_pkg::MEM_DATA_W
) ();

    // burst request
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_len;

    // memory read port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    // output stream
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    // status
    logic              busy;

    modport master (
        input  req_valid, req_addr, req_len, mem_data, out_ready,
        output req_ready, mem_addr, out_valid, out_data, out_last, busy
    );

    modport slave (
        output req_valid, req_addr, req_len, mem_data, out_ready,
        input  req_ready, mem_addr, out_valid, out_data, out_last, busy
    );

endinterface

// File: rtl/mem_stream_reader_stream_out.sv
// Single-entry valid/ready output register with a 'last' marker. A load is
// taken only when the slot is empty or being drained in the same cycle, so a
// held word never changes until the consumer accepts it.
module stream_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              can_load_o,
    output logic              valid_o,
    output logic              last_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    logic [DATA_W-1:0] data_q,  data_d;

    assign can_load_o = !valid_q || ready_i;

    // Load a new word, or empty the slot when the held word is accepted.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load_i && can_load_o) begin
            valid_d = 1'b1;
            last_d  = last_i;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // Output slot register; the data word is left as-is when emptied.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader for the scratch memory: accepts (start, length-1), walks the
// combinational read port with a wrapping address and streams one word per
// cycle through a valid/ready register, flagging the final word.
module mem_stream_reader
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    mem_stream_reader_if.master bus
);

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;

    logic              can_load;
    logic              load_en;
    logic              last_word;
    logic              out_valid;
    logic              out_last;
    logic [DATA_W-1:0] out_data;

    // A word is captured every READ cycle in which the output slot is free,
    // so a stalled consumer freezes address, count and output together.
    assign load_en   = (state_q == READ) && can_load;
    assign last_word = (remain_q == '0);

    // Next-state and address/count bookkeeping.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    cur_addr_d = bus.req_addr;
                    remain_d   = bus.req_len;
                    state_d    = READ;
                end
            end
            READ: begin
                if (load_en) begin
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    remain_d   = remain_q - ADDR_W'(1);
                    if (last_word) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, address and remaining-count registers; reset aborts any burst.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
        end
    end

    stream_out_reg #(
        .DATA_W (DATA_W)
    ) u_stream_out (
        .clock      (clock),
        .reset      (reset),
        .load_i     (load_en),
        .data_i     (bus.mem_data),
        .last_i     (last_word),
        .ready_i    (bus.out_ready),
        .can_load_o (can_load),
        .valid_o    (out_valid),
        .last_o     (out_last),
        .data_o     (out_data)
    );

    // The held address is presented in every state; it only moves on a load.
    assign bus.mem_addr  = cur_addr_q;
    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = out_data;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: a burst-level model (expected
// word queue, words-accepted count) is checked every cycle, plus literal
// expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_mem_stream_reader;
    import mem_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem [DEPTH];
    assign bus.mem_data = mem[bus.mem_addr];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // ---------------- behavioural model ----------------
    bit            m_busy = 0;
    bit            was_busy;
    int            m_start = 0;
    int            m_acc = 0;
    int            m_len = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] log_data[$];
    int            log_last[$];
    int            addr_log[$];
    int            cyc = 0;
    int            req_cyc = 0;
    int            lat = -1;
    bit            first_pending = 0;
    bit            prev_valid = 0;
    bit            prev_ready = 0;
    logic [DW-1:0] prev_data = '0;
    bit            prev_last = 0;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            m_busy = 0; m_start = 0; m_acc = 0; m_len = 0;
            exp_q.delete();
            prev_valid = 0; first_pending = 0;
        end else begin
            chk("busy", int'(bus.busy), int'(m_busy));
            chk("req_ready", int'(bus.req_ready), int'(!m_busy));
            chk("mem_addr", int'(bus.mem_addr),
                (m_start + m_acc + int'(bus.out_valid)) % DEPTH);
            if (!m_busy) chk("idle_valid", int'(bus.out_valid), 0);
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", int'(bus.out_valid), 1);
                chk("stall_data", int'(bus.out_data), int'(prev_data));
                chk("stall_last", int'(bus.out_last), int'(prev_last));
            end
            if (m_busy && bus.out_valid && first_pending) begin
                lat = cyc - req_cyc;
                first_pending = 0;
            end
            // a word is fetched at the next edge if the slot frees up and words remain
            if (m_busy && (!bus.out_valid || bus.out_ready) &&
                (m_acc + int'(bus.out_valid)) < m_len)
                addr_log.push_back(int'(bus.mem_addr));

            was_busy = m_busy;
            if (bus.out_valid && bus.out_ready) begin
                chk("word_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("data", int'(bus.out_data), int'(exp_q[0]));
                    chk("last", int'(bus.out_last), int'(exp_q.size() == 1));
                    log_data.push_back(bus.out_data);
                    log_last.push_back(int'(bus.out_last));
                    void'(exp_q.pop_front());
                    m_acc++;
                    if (exp_q.size() == 0) m_busy = 0;
                end
            end
            if (bus.req_valid && !was_busy) begin
                m_busy  = 1;
                m_start = int'(bus.req_addr);
                m_len   = int'(bus.req_len) + 1;
                m_acc   = 0;
                for (int i = 0; i < m_len; i++)
                    exp_q.push_back(mem[AW'((m_start + i) % DEPTH)]);
                req_cyc = cyc;
                first_pending = 1;
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_ready(int mode, int c);
        case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (c % 3 == 0);
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic clear_logs();
        log_data.delete(); log_last.delete(); addr_log.delete(); lat = -1;
    endtask

    task automatic run_burst(int addr, int len, int mode, bit noise, output int cycles);
        @(posedge clock); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = AW'(addr);
        bus.req_len   = AW'(len);
        set_ready(mode, 0);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        cycles = 0;
        while (m_busy && cycles < 200) begin
            cycles++;
            set_ready(mode, cycles);
            if (noise) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_addr  = AW'($urandom);
                bus.req_len   = AW'($urandom);
            end
            @(posedge clock); #1;
        end
        bus.req_valid = 1'b0;
        chk("burst_done", int'(m_busy), 0);
        $display("burst addr=%0d len=%0d mode=%0d words=%0d cycles=%0d",
                 addr, len, mode, log_data.size(), cycles);
    endtask

    int cycles;
    int exp_t2[4]  = '{140, 150, 0, 10};
    int exp_a2[4]  = '{14, 15, 0, 1};
    int lasts;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(10 * i);

        // reset state
        #12;
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_last", int'(bus.out_last), 0);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_req_ready", int'(bus.req_ready), 1);
        chk("rst_mem_addr", int'(bus.mem_addr), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // single word
        clear_logs();
        run_burst(3, 0, 0, 0, cycles);
        chk("t1_cycles", cycles, 2);
        chk("t1_latency", lat, 2);
        chk("t1_count", log_data.size(), 1);
        if (log_data.size() == 1) begin
            chk("t1_data", int'(log_data[0]), 30);
            chk("t1_last", log_last[0], 1);
        end

        // wrap around the top of memory
        clear_logs();
        run_burst(14, 3, 0, 0, cycles);
        chk("t2_cycles", cycles, 5);
        chk("t2_count", log_data.size(), 4);
        chk("t2_addr_count", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < log_data.size(); i++) begin
            chk("t2_data", int'(log_data[i]), exp_t2[i]);
            chk("t2_last", log_last[i], int'(i == 3));
        end
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk("t2_mem_addr", addr_log[i], exp_a2[i]);

        // backpressure 1,0,0,1,...
        clear_logs();
        run_burst(0, 4, 1, 0, cycles);
        chk("t3_count", log_data.size(), 5);
        for (int i = 0; i < 5 && i < log_data.size(); i++)
            chk("t3_data", int'(log_data[i]), 10 * i);

        // request while busy is ignored, next one after IDLE is taken
        clear_logs();
        run_burst(2, 2, 0, 1, cycles);
        chk("t4a_count", log_data.size(), 3);
        clear_logs();
        run_burst(7, 1, 0, 0, cycles);
        chk("t4b_count", log_data.size(), 2);
        if (log_data.size() == 2) begin
            chk("t4b_data0", int'(log_data[0]), 70);
            chk("t4b_data1", int'(log_data[1]), 80);
        end

        // full depth
        clear_logs();
        run_burst(5, 15, 0, 0, cycles);
        chk("t5_cycles", cycles, 17);
        chk("t5_count", log_data.size(), 16);
        if (log_data.size() == 16) chk("t5_last_data", int'(log_data[15]), 40);
        if (addr_log.size() == 16) begin
            chk("t5_addr_first", addr_log[0], 5);
            chk("t5_addr_wrap", addr_log[11], 0);
        end

        // reset mid-burst
        clear_logs();
        @(posedge clock); #1;
        bus.req_valid = 1'b1; bus.req_addr = '0; bus.req_len = AW'(5);
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && m_acc < 2; i++) begin
            @(posedge clock); #1;
        end
        chk("t6_accepted_before_reset", m_acc, 2);
        reset = 1'b1;
        #1;
        chk("t6_valid", int'(bus.out_valid), 0);
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_req_ready", int'(bus.req_ready), 1);
        chk("t6_last", int'(bus.out_last), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        lasts = 0;
        foreach (log_last[i]) lasts += log_last[i];
        chk("t6_no_last", lasts, 0);
        clear_logs();
        run_burst(0, 1, 0, 0, cycles);
        chk("t6b_count", log_data.size(), 2);
        if (log_data.size() == 2) begin
            chk("t6b_data0", int'(log_data[0]), 0);
            chk("t6b_data1", int'(log_data[1]), 10);
        end

        // randomized bursts against the model
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            clear_logs();
            run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                      2, 1, cycles);
        end

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
